// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage boundary register with a 2-entry skid buffer and flush/drain bubbles.
// Optional stall/bubble performance counters are enabled with `define PIPE_STAGE_PERF_EN.
module pipe_stage_buf #(
  parameter int PAYLOAD_W = 106,
  parameter int CTRL_W = 12,
  parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [1:0]           occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state;
  logic                   main_valid;
  logic [PAYLOAD_W-1:0]   main_payload;
  logic [CTRL_W-1:0]      main_ctrl;
  logic                   skid_valid;
  logic [PAYLOAD_W-1:0]   skid_payload;
  logic [CTRL_W-1:0]      skid_ctrl;
  logic                   acc;
  logic                   pop;

  assign acc         = in_valid & in_ready;
  assign pop         = main_valid & out_ready;
  assign out_valid   = main_valid;
  assign out_payload = main_payload;
  assign out_ctrl    = main_ctrl;
  assign occupancy   = state;

  // in_ready is only dropped on the ONE->FULL transition and restored when FULL drains.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state        <= EMPTY;
      in_ready     <= 1'b1;
      main_valid   <= 1'b0;
      main_payload <= '0;
      main_ctrl    <= NOP_CTRL;
      skid_valid   <= 1'b0;
      skid_payload <= '0;
      skid_ctrl    <= NOP_CTRL;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state        <= ONE;
            main_valid   <= 1'b1;
            main_payload <= in_payload;
            main_ctrl    <= in_ctrl;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_payload <= in_payload;
            main_ctrl    <= in_ctrl;
          end else if (acc) begin
            state        <= FULL;
            in_ready     <= 1'b0;
            skid_valid   <= 1'b1;
            skid_payload <= in_payload;
            skid_ctrl    <= in_ctrl;
          end else if (pop) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            main_ctrl  <= NOP_CTRL;
          end
        end
        FULL: begin
          if (pop) begin
            state        <= ONE;
            in_ready     <= 1'b1;
            main_valid   <= skid_valid;
            main_payload <= skid_payload;
            main_ctrl    <= skid_ctrl;
            skid_valid   <= 1'b0;
            skid_ctrl    <= NOP_CTRL;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters; flush deliberately leaves them alone so stats survive mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!main_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`else
  // Counters compiled out.
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: accepted entries are queued and matched against popped outputs.
// Counter checks are included when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_buf;
  localparam int PAYLOAD_W = 106;
  localparam int CTRL_W = 12;
  localparam int CNT_W = 32;
  localparam logic [CTRL_W-1:0] NOP = '0;
  localparam int SBW = PAYLOAD_W + CTRL_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload = '0;
  logic [CTRL_W-1:0]    in_ctrl = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [CTRL_W-1:0]    out_ctrl;
  logic [1:0]           occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     bubble_cnt;
`endif

  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] got_q[$];
  int checks = 0;
  int passed = 0;
  bit dummy;

  pipe_stage_buf #(
    .PAYLOAD_W(PAYLOAD_W),
    .CTRL_W(CTRL_W),
    .NOP_CTRL(NOP),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_payload(in_payload),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_payload(out_payload),
    .out_ctrl(out_ctrl),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [CTRL_W-1:0] mk_ctrl(input int unsigned v);
    logic [CTRL_W-1:0] c;
    c = CTRL_W'(v);
    c[CTRL_W-1] = 1'b1;
    return c;
  endfunction

  task automatic drive(input bit v, input int unsigned p, input logic [CTRL_W-1:0] c,
                       input bit ordy, input bit fl);
    in_valid   = v;
    in_payload = PAYLOAD_W'(p);
    in_ctrl    = c;
    out_ready  = ordy;
    flush      = fl;
  endtask

  // Records handshakes mid-cycle, then steps past the next rising edge.
  task automatic advance(output bit accepted);
    @(negedge clk);
    accepted = 1'b0;
    if (in_valid && in_ready && !flush && !rst) begin
      exp_q.push_back({in_payload, in_ctrl});
      accepted = 1'b1;
    end
    if (out_valid && out_ready) got_q.push_back({out_payload, out_ctrl});
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [SBW-1:0] got, input logic [SBW-1:0] exp);
    checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 32'h99, mk_ctrl(1), 1, 0);
    advance(dummy);
    advance(dummy);
    chk("reset out_valid", SBW'(out_valid), SBW'(0));
    chk("reset out_ctrl", SBW'(out_ctrl), SBW'(NOP));
    chk("reset out_payload", SBW'(out_payload), SBW'(0));
    chk("reset in_ready", SBW'(in_ready), SBW'(1));
    chk("reset occupancy", SBW'(occupancy), SBW'(0));
    rst = 1'b0;
    drive(0, 0, NOP, 0, 0);
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_streaming();
    logic [SBW-1:0] e;
    for (int i = 1; i <= 3; i++) begin
      drive(1, i, mk_ctrl(i), 1, 0);
      advance(dummy);
      chk("stream out_valid", SBW'(out_valid), SBW'(1));
      chk("stream out_payload", SBW'(out_payload), SBW'(i));
      chk("stream in_ready", SBW'(in_ready), SBW'(1));
    end
    drive(0, 0, NOP, 1, 0);
    advance(dummy);
    chk("stream pops", SBW'(got_q.size()), SBW'(3));
    while (got_q.size() > 0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("stream scoreboard", got_q.pop_front(), e);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    logic [SBW-1:0] g;
    drive(1, 32'hA, mk_ctrl(32'hA), 0, 0);
    advance(dummy);
    drive(1, 32'hB, mk_ctrl(32'hB), 0, 0);
    advance(dummy);
    chk("bp occupancy full", SBW'(occupancy), SBW'(2));
    chk("bp in_ready low", SBW'(in_ready), SBW'(0));
    drive(1, 32'hC, mk_ctrl(32'hC), 0, 0);
    advance(acc);
    chk("bp C held off", SBW'(acc), SBW'(0));
    chk("bp payload stable", SBW'(out_payload), SBW'(32'hA));
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (got_q.size() < 3 || in_valid); i++) begin
      advance(acc);
      if (acc) in_valid = 1'b0;
    end
    chk("bp pop count", SBW'(got_q.size()), SBW'(3));
    for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      chk("bp order", g, {PAYLOAD_W'(32'hA + i), mk_ctrl(32'hA + i)});
      chk("bp scoreboard", g, (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
    end
    chk("bp leftovers", SBW'(exp_q.size()), SBW'(0));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_flush_full();
    drive(1, 32'h11, mk_ctrl(32'h11), 0, 0);
    advance(dummy);
    drive(1, 32'h12, mk_ctrl(32'h12), 0, 0);
    advance(dummy);
    chk("flush pre occupancy", SBW'(occupancy), SBW'(2));
    drive(1, 32'hD, mk_ctrl(32'hD), 0, 1);
    advance(dummy);
    drive(0, 0, NOP, 0, 0);
    chk("flush out_valid", SBW'(out_valid), SBW'(0));
    chk("flush out_ctrl", SBW'(out_ctrl), SBW'(NOP));
    chk("flush occupancy", SBW'(occupancy), SBW'(0));
    chk("flush in_ready", SBW'(in_ready), SBW'(1));
    chk("flush out_payload", SBW'(out_payload), SBW'(0));
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) advance(dummy);
    chk("flush nothing emerges", SBW'(got_q.size()), SBW'(0));
    got_q.delete();
  endtask

  task automatic test_drain_bubble();
    drive(1, 32'h77, 12'h5A5, 1, 0);
    advance(dummy);
    chk("drain valid", SBW'(out_valid), SBW'(1));
    chk("drain ctrl", SBW'(out_ctrl), SBW'(12'h5A5));
    drive(0, 0, NOP, 1, 0);
    advance(dummy);
    chk("drain bubble valid", SBW'(out_valid), SBW'(0));
    chk("drain bubble ctrl", SBW'(out_ctrl), SBW'(NOP));
    chk("drain payload held", SBW'(out_payload), SBW'(32'h77));
    chk("drain popped", (got_q.size() > 0) ? got_q.pop_front() : 'x,
        (exp_q.size() > 0) ? exp_q.pop_front() : SBW'(0));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_rst_mid();
    drive(1, 32'h21, mk_ctrl(32'h21), 0, 0);
    advance(dummy);
    drive(1, 32'h22, mk_ctrl(32'h22), 0, 0);
    advance(dummy);
    rst = 1'b1;
    drive(0, 0, NOP, 0, 0);
    advance(dummy);
    rst = 1'b0;
    chk("rstmid occupancy", SBW'(occupancy), SBW'(0));
    chk("rstmid out_valid", SBW'(out_valid), SBW'(0));
    chk("rstmid out_payload", SBW'(out_payload), SBW'(0));
    chk("rstmid in_ready", SBW'(in_ready), SBW'(1));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    bit stalled;
    logic [SBW-1:0] held;
    for (int cyc = 0; cyc < 320; cyc++) begin
      if (cyc < 300) begin
        in_valid   = ($urandom_range(0, 3) != 0);
        in_payload = PAYLOAD_W'({$urandom(), $urandom(), $urandom(), $urandom()});
        in_ctrl    = mk_ctrl($urandom());
        out_ready  = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      stalled = out_valid && !out_ready;
      held = {out_payload, out_ctrl};
      advance(dummy);
      while (got_q.size() > 0)
        chk("b2b scoreboard", got_q.pop_front(), (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
      chk("b2b occupancy", SBW'(occupancy), SBW'(exp_q.size()));
      chk("b2b in_ready", SBW'(in_ready), SBW'(exp_q.size() != 2));
      if (stalled) chk("b2b stable", {out_payload, out_ctrl}, held);
      if (out_valid) begin
        checks++;
        if (out_ctrl === NOP) $display("[TB] FAIL b2b valid nop: got %0h expected non-NOP", out_ctrl);
        else passed++;
      end
    end
    chk("b2b drained", SBW'(exp_q.size()), SBW'(0));
    exp_q.delete();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_counters();
    rst = 1'b1;
    drive(0, 0, NOP, 0, 0);
    advance(dummy);
    rst = 1'b0;
    chk("cnt rst stall", SBW'(stall_cnt), SBW'(0));
    chk("cnt rst bubble", SBW'(bubble_cnt), SBW'(0));
    drive(1, 32'h42, mk_ctrl(32'h42), 0, 0);
    advance(dummy);
    drive(0, 0, NOP, 0, 0);
    for (int i = 0; i < 3; i++) advance(dummy);
    chk("cnt stall 3", SBW'(stall_cnt), SBW'(3));
    chk("cnt bubble 1", SBW'(bubble_cnt), SBW'(1));
    flush = 1'b1;
    advance(dummy);
    flush = 1'b0;
    advance(dummy);
    chk("cnt flush stall", SBW'(stall_cnt), SBW'(4));
    chk("cnt flush bubble", SBW'(bubble_cnt), SBW'(2));
    rst = 1'b1;
    advance(dummy);
    rst = 1'b0;
    chk("cnt clear stall", SBW'(stall_cnt), SBW'(0));
    chk("cnt clear bubble", SBW'(bubble_cnt), SBW'(0));
    exp_q.delete();
    got_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_drain_bubble();
    test_rst_mid();
    test_back_to_back();
`ifdef PIPE_STAGE_PERF_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
